// File: rtl/fp_mul_result_collector.sv
// fp_mul_result_collector: 2-entry FIFO for FP32 multiplier results with sticky flags and saturating counters
module fp_mul_result_collector #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_result,
    input  logic               in_exception,
    input  logic               in_overflow,
    input  logic               in_underflow,
    input  logic               in_invalid,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_result,
    output logic [3:0]         out_flags,
    input  logic               clear_sticky,
    output logic [3:0]         sticky_flags,
    output logic [COUNT_W-1:0] accept_count,
    output logic [COUNT_W-1:0] invalid_count
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t             r_state, w_next;
    logic [35:0]        r_head, r_tail;
    logic [3:0]         r_sticky;
    logic [COUNT_W-1:0] r_acc_cnt, r_inv_cnt;
    logic [3:0]         w_in_flags;
    logic [35:0]        w_entry;
    logic               w_accept, w_pop, w_inv;

    assign w_in_flags    = {in_invalid, in_exception, in_overflow, in_underflow};
    assign w_entry       = {in_result, w_in_flags};
    assign in_ready      = r_state != FULL;
    assign out_valid     = r_state != EMPTY;
    assign w_accept      = in_valid && in_ready;
    assign w_pop         = out_valid && out_ready;
    assign w_inv         = w_accept && in_invalid;
    assign {out_result, out_flags} = r_head;
    assign sticky_flags  = r_sticky;
    assign accept_count  = r_acc_cnt;
    assign invalid_count = r_inv_cnt;

    // occupancy next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            EMPTY:   w_next = w_accept ? ONE : EMPTY;
            ONE:     w_next = (w_accept && !w_pop) ? FULL : (!w_accept && w_pop) ? EMPTY : ONE;
            FULL:    w_next = w_pop ? ONE : FULL;
            default: w_next = EMPTY;
        endcase
    end

    // occupancy state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= EMPTY;
        else        r_state <= w_next;
    end

    // head/tail storage: new entry lands in head when it will be the only one, else in tail
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_accept && (r_state == EMPTY || w_pop)) r_head <= w_entry;
            else if (w_pop && r_state == FULL)          r_head <= r_tail;
            if (w_accept && r_state == ONE && !w_pop)   r_tail <= w_entry;
        end
    end

    // sticky flags and saturating counters; a clear coinciding with an accept keeps only that accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sticky  <= '0;
            r_acc_cnt <= '0;
            r_inv_cnt <= '0;
        end else if (clear_sticky) begin
            r_sticky  <= w_accept ? w_in_flags : 4'b0;
            r_acc_cnt <= COUNT_W'(w_accept);
            r_inv_cnt <= COUNT_W'(w_inv);
        end else begin
            r_sticky  <= w_accept ? (r_sticky | w_in_flags) : r_sticky;
            r_acc_cnt <= (w_accept && r_acc_cnt != '1) ? r_acc_cnt + COUNT_W'(1) : r_acc_cnt;
            r_inv_cnt <= (w_inv && r_inv_cnt != '1) ? r_inv_cnt + COUNT_W'(1) : r_inv_cnt;
        end
    end
endmodule

// File: tb/tb_fp_mul_result_collector.sv
// tb_fp_mul_result_collector: directed scenarios plus randomized traffic against a queue-based model
module tb_fp_mul_result_collector;
    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          in_valid = 0, in_ready;
    logic [31:0]   in_result = 0;
    logic          in_exception = 0, in_overflow = 0, in_underflow = 0, in_invalid = 0;
    logic          out_valid, out_ready = 0;
    logic [31:0]   out_result;
    logic [3:0]    out_flags;
    logic          clear_sticky = 0;
    logic [3:0]    sticky_flags;
    logic [CW-1:0] accept_count, invalid_count;

    logic [35:0]   m_q[$];
    logic [3:0]    m_sticky = 0;
    int            m_acc = 0, m_inv = 0;
    int            checks = 0, errors = 0;

    fp_mul_result_collector #(.COUNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_exception(in_exception), .in_overflow(in_overflow),
        .in_underflow(in_underflow), .in_invalid(in_invalid),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags),
        .clear_sticky(clear_sticky), .sticky_flags(sticky_flags),
        .accept_count(accept_count), .invalid_count(invalid_count)
    );

    always #5 clk = ~clk;

    // drive one cycle of inputs, advance the model, and settle 1 time unit after the edge
    task automatic cyc(input logic v, input logic [31:0] r, input logic [3:0] f, input logic ordy, input logic clr);
        bit acc, pop;
        in_valid = v; in_result = r; out_ready = ordy; clear_sticky = clr;
        {in_invalid, in_exception, in_overflow, in_underflow} = f;
        acc = v && m_q.size() < 2;
        pop = m_q.size() > 0 && ordy;
        if (!rst_n) begin
            m_q.delete(); m_sticky = 0; m_acc = 0; m_inv = 0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (acc) m_q.push_back({r, f});
            m_sticky = clr ? (acc ? f : 4'b0) : (acc ? (m_sticky | f) : m_sticky);
            m_acc = clr ? int'(acc) : (m_acc + int'(acc) > MAX ? MAX : m_acc + int'(acc));
            m_inv = clr ? int'(acc && f[3]) : (m_inv + int'(acc && f[3]) > MAX ? MAX : m_inv + int'(acc && f[3]));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 0;
        cyc(1, 32'hDEADBEEF, 4'b1111, 1, 0);
        cyc(1, 32'hDEADBEEF, 4'b1111, 0, 1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if ({out_result, out_flags} !== 36'h0) begin errors++; $display("FAIL reset_head got %h exp 0", {out_result, out_flags}); end
        checks++; if ({sticky_flags, accept_count, invalid_count} !== '0) begin errors++; $display("FAIL reset_stats got %h/%0d/%0d exp 0", sticky_flags, accept_count, invalid_count); end
        rst_n = 1;
    endtask

    task automatic test_pass_through;
        cyc(1, 32'h40C00000, 4'b0000, 1, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pass_valid got %b exp 1", out_valid); end
        checks++; if (out_result !== 32'h40C00000 || out_flags !== 4'b0000) begin errors++; $display("FAIL pass_data got %h/%b exp 40c00000/0000", out_result, out_flags); end
        checks++; if (accept_count !== 4'd1) begin errors++; $display("FAIL pass_count got %0d exp 1", accept_count); end
        cyc(0, 0, 0, 1, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pass_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_backpressure;
        cyc(1, 32'h3F800000, 0, 0, 0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %b exp 1", in_ready); end
        cyc(1, 32'h40000000, 0, 0, 0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready2 got %b exp 0", in_ready); end
        cyc(1, 32'h40400000, 0, 0, 0);
        checks++; if (out_result !== 32'h3F800000 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold got %h/%b exp 3f800000/0", out_result, in_ready); end
        cyc(1, 32'h40400000, 0, 1, 0);
        checks++; if (out_result !== 32'h40000000 || !out_valid) begin errors++; $display("FAIL bp_second got %h/%b exp 40000000/1", out_result, out_valid); end
        cyc(0, 0, 0, 1, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", out_valid); end
        checks++; if (accept_count !== 4'd3) begin errors++; $display("FAIL bp_count got %0d exp 3", accept_count); end
    endtask

    task automatic test_overflow_flag;
        rst_n = 0; cyc(0, 0, 0, 0, 0); rst_n = 1;
        cyc(1, 32'hFF800000, 4'b1010, 0, 0);
        checks++; if (out_flags !== 4'b1010 || out_result !== 32'hFF800000) begin errors++; $display("FAIL ovf_head got %h/%b exp ff800000/1010", out_result, out_flags); end
        checks++; if (sticky_flags !== 4'b1010) begin errors++; $display("FAIL ovf_sticky got %b exp 1010", sticky_flags); end
        checks++; if (invalid_count !== 4'd1) begin errors++; $display("FAIL ovf_invcnt got %0d exp 1", invalid_count); end
    endtask

    task automatic test_simul_clear;
        cyc(1, 32'h1, 4'b1100, 1, 1);
        checks++; if (sticky_flags !== 4'b1100) begin errors++; $display("FAIL clr_pre got %b exp 1100", sticky_flags); end
        cyc(1, 32'h2, 4'b0001, 1, 1);
        checks++; if (sticky_flags !== 4'b0001 || accept_count !== 4'd1 || invalid_count !== 4'd0) begin errors++; $display("FAIL clr_accept got %b/%0d/%0d exp 0001/1/0", sticky_flags, accept_count, invalid_count); end
        checks++; if (out_result !== 32'h2 || !out_valid) begin errors++; $display("FAIL clr_fifo got %h/%b exp 2/1", out_result, out_valid); end
        cyc(0, 0, 0, 1, 0);
    endtask

    task automatic test_saturation;
        cyc(0, 0, 0, 1, 1);
        for (int i = 0; i < 20; i++) begin
            cyc(1, i, 4'b1000, 1, 0);
            if (i == 14 || i == 19) begin
                checks++; if (accept_count !== 4'd15 || invalid_count !== 4'd15) begin errors++; $display("FAIL sat_%0d got %0d/%0d exp 15/15", i, accept_count, invalid_count); end
            end
        end
        cyc(0, 0, 0, 1, 0);
    endtask

    task automatic test_reset_mid;
        cyc(1, 32'hA, 4'b0011, 0, 0);
        cyc(1, 32'hB, 4'b0100, 0, 0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_full got %b exp 0", in_ready); end
        rst_n = 0;
        cyc(1, 32'hC, 4'b1111, 1, 0);
        rst_n = 1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_hs got %b/%b exp 0/1", out_valid, in_ready); end
        checks++; if ({sticky_flags, accept_count, invalid_count, out_result, out_flags} !== '0) begin errors++; $display("FAIL mid_state got %b/%0d/%0d/%h/%b exp 0", sticky_flags, accept_count, invalid_count, out_result, out_flags); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            cyc($urandom_range(0, 3) != 0, $urandom, 4'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0);
            checks++; if (out_valid !== (m_q.size() > 0) || in_ready !== (m_q.size() < 2)) begin errors++; $display("FAIL rnd_hs cyc %0d got %b/%b exp %0d entries", i, out_valid, in_ready, m_q.size()); end
            if (m_q.size() > 0) begin
                checks++; if ({out_result, out_flags} !== m_q[0]) begin errors++; $display("FAIL rnd_head cyc %0d got %h exp %h", i, {out_result, out_flags}, m_q[0]); end
            end
            checks++; if (sticky_flags !== m_sticky || int'(accept_count) != m_acc || int'(invalid_count) != m_inv) begin errors++; $display("FAIL rnd_stats cyc %0d got %b/%0d/%0d exp %b/%0d/%0d", i, sticky_flags, accept_count, invalid_count, m_sticky, m_acc, m_inv); end
        end
        rst_n = 1;
    endtask

    initial begin
        test_reset;
        test_pass_through;
        test_backpressure;
        test_overflow_flag;
        test_simul_clear;
        test_saturation;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
